// File: rtl/cdb_rr_arbiter_if.sv
// CDB arbiter bus bundle: per-unit requests and payloads in, one registered CDB beat out.
// The slave modport is the arbiter side; the master modport is the execution units and CDB consumer.
interface cdb_rr_arbiter_if #(
    parameter int EU_N   = 8,
    parameter int DATA_W = 64
);
    localparam int IDX_W = $clog2(EU_N);

    logic                     flush_i;
    logic [EU_N-1:0]          valid_i;
    logic [EU_N-1:0]          ready_o;
    logic [EU_N*DATA_W-1:0]   data_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [DATA_W-1:0]        data_o;
    logic [IDX_W-1:0]         grant_idx_o;

    modport master (
        output flush_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, grant_idx_o
    );

    modport slave (
        input  flush_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, grant_idx_o
    );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// Round-robin arbiter sharing the common data bus among the execution units.
// One unit is granted per cycle into a single-entry output register that drives the CDB.
module cdb_rr_arbiter #(
    parameter int EU_N   = 8,
    parameter int DATA_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    cdb_rr_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(EU_N);
    localparam int CW    = IDX_W + 1;

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  ptr_q;

    logic              accept;
    logic              found;
    logic [IDX_W-1:0]  gnt_idx;
    logic [CW-1:0]     cand;
    logic [EU_N-1:0]   ready;

    // The register can take a new beat when empty or draining this cycle.
    assign accept = (!valid_q || bus.ready_i) && !bus.flush_i && rst_n_i;

    // NOTE: every variable gets a default before the search so no latch is inferred.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < EU_N; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(EU_N)) begin
                cand = cand - CW'(EU_N);
            end
            if (!found && bus.valid_i[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (accept && found) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    assign bus.ready_o = ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            // NOTE: data_q is reset although valid_q qualifies it, because data_o must read 0 out of reset.
            data_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else if (bus.flush_i) begin
            valid_q <= 1'b0;
        end else if (accept && found) begin
            valid_q <= 1'b1;
            data_q  <= bus.data_i[gnt_idx*DATA_W +: DATA_W];
            idx_q   <= gnt_idx;
            // Explicit wrap keeps non-power-of-2 unit counts in range.
            ptr_q   <= (gnt_idx == IDX_W'(EU_N - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (bus.ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.data_o      = data_q;
    assign bus.grant_idx_o = idx_q;
endmodule
